// File: rtl/fft_lane_serializer.sv
// Ping-pong reorder buffer: captures parallel FFT beats (bin k of every lane) and
// replays them lane by lane as a single complex stream with per-lane tlast.
module fft_lane_serializer #(
  parameter int LANES  = 4,
  parameter int BINS   = 512,
  parameter int LANE_W = $clog2(LANES),
  parameter int BIN_W  = $clog2(BINS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LANES*32:0]   s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [32:0]         m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [LANE_W-1:0]   m_lane,
  output logic                m_frame_end,
  output logic                frame_err
);
  localparam int DATA_W = 32;
  localparam logic [BIN_W-1:0]  LAST_BIN  = BIN_W'(BINS - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, RELEASE} rd_state_t;

  function automatic logic [DATA_W-1:0] lane_word(input logic [LANES*32:0] beat, input int lane);
    return beat[DATA_W*lane+1 +: DATA_W];
  endfunction

  logic [DATA_W-1:0] mem [LANES][2*BINS];
  logic [BIN_W:0]    len [2];
  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic [BIN_W-1:0]  wr_bin;
  logic [BIN_W-1:0]  rd_bin;
  logic [LANE_W-1:0] rd_lane;
  rd_state_t         rd_state;

  logic              s_tlast;
  logic              wr_fire;
  logic              wr_last_bin;
  logic              wr_close;
  logic [BIN_W:0]    rd_len;
  logic              rd_last_bin;
  logic              pop;
  logic [1:0]        occ;
  logic              vld_p0;

  logic              vld_p1;
  logic              tlast_p1;
  logic              fend_p1;
  logic [LANE_W-1:0] lane_p1;
  logic [DATA_W-1:0] q_p1 [LANES];
  logic [32:0]       tdata_p1;

  logic              tail_vld;
  logic              tail_fend;
  logic [32:0]       tail_tdata;
  logic [LANE_W-1:0] tail_lane;

  assign s_tlast     = s_tdata[0];
  assign s_tready    = !full[wr_bank];
  assign wr_fire     = s_tvalid && s_tready;
  assign wr_last_bin = (wr_bin == LAST_BIN);
  assign wr_close    = wr_fire && (s_tlast || wr_last_bin);

  assign rd_len      = len[rd_bank];
  assign rd_last_bin = ({1'b0, rd_bin} == rd_len - 1'b1);
  assign pop         = m_tvalid && m_tready;
  assign occ         = 2'(m_tvalid) + 2'(tail_vld) + 2'(vld_p1);
  // Issue only if the read in flight plus the skid contents still fit in two entries.
  assign vld_p0      = (rd_state == DRAIN) && (occ <= 2'(pop) + 2'd1);

  // Write side: all lanes of a beat land at the same bin address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank   <= 1'b0;
      wr_bin    <= '0;
      full      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= wr_close && (s_tlast != wr_last_bin);
      if (wr_fire) begin
        if (wr_close) begin
          len[wr_bank]  <= {1'b0, wr_bin} + 1'b1;
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
          wr_bin        <= '0;
        end else begin
          wr_bin <= wr_bin + 1'b1;
        end
      end
      if (rd_state == RELEASE) full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (wr_fire) mem[l][{wr_bank, wr_bin}] <= lane_word(s_tdata, l);
      if (vld_p0)  q_p1[l] <= mem[l][{rd_bank, rd_bin}];
    end
  end

  // Stage p0: read address generation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state <= IDLE;
      rd_bank  <= 1'b0;
      rd_lane  <= '0;
      rd_bin   <= '0;
    end else begin
      case (rd_state)
        IDLE: begin
          if (full[rd_bank]) begin
            rd_lane  <= '0;
            rd_bin   <= '0;
            rd_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (vld_p0) begin
            if (rd_last_bin) begin
              rd_bin <= '0;
              if (rd_lane == LAST_LANE) rd_state <= RELEASE;
              else                      rd_lane  <= rd_lane + 1'b1;
            end else begin
              rd_bin <= rd_bin + 1'b1;
            end
          end
        end
        RELEASE: begin
          rd_bank  <= !rd_bank;
          rd_state <= IDLE;
        end
        default: rd_state <= IDLE;
      endcase
    end
  end

  // Stage p1: registered RAM output with its beat tags.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      lane_p1  <= rd_lane;
      tlast_p1 <= rd_last_bin;
      fend_p1  <= rd_last_bin && (rd_lane == LAST_LANE);
    end
  end

  assign tdata_p1 = {q_p1[lane_p1], tlast_p1};

  // Stage p2: two-entry skid; the head entry drives the output ports directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_tvalid    <= 1'b0;
      m_tdata     <= '0;
      m_lane      <= '0;
      m_frame_end <= 1'b0;
      tail_vld    <= 1'b0;
    end else if (!m_tvalid || pop) begin
      if (tail_vld) begin
        m_tvalid    <= 1'b1;
        m_tdata     <= tail_tdata;
        m_lane      <= tail_lane;
        m_frame_end <= tail_fend;
        tail_vld    <= vld_p1;
      end else begin
        m_tvalid <= vld_p1;
        if (vld_p1) begin
          m_tdata     <= tdata_p1;
          m_lane      <= lane_p1;
          m_frame_end <= fend_p1;
        end
      end
    end else if (vld_p1) begin
      tail_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1 && (tail_vld || (m_tvalid && !pop))) begin
      tail_tdata <= tdata_p1;
      tail_lane  <= lane_p1;
      tail_fend  <= fend_p1;
    end
  end

endmodule

// File: tb/tb_fft_lane_serializer.sv
// Bench for fft_lane_serializer: frame-level reference queue plus directed scenarios.
`timescale 1ns/1ps
module tb_fft_lane_serializer;
  localparam int LANES  = 4;
  localparam int BINS   = 8;
  localparam int LANE_W = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [LANES*32:0]  s_tdata;
  logic               s_tvalid;
  logic               s_tready;
  logic [32:0]        m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic [LANE_W-1:0]  m_lane;
  logic               m_frame_end;
  logic               frame_err;

  fft_lane_serializer #(.LANES(LANES), .BINS(BINS)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_lane(m_lane), .m_frame_end(m_frame_end), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [32:0]       tdata;
    logic [LANE_W-1:0] lane;
    logic              fend;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] pf [LANES][BINS];
  int          pf_len = 0;
  int          closed = 0;
  int          done = 0;
  int          out_cnt = 0;
  int          tlast_cnt = 0;
  int          fend_cnt = 0;
  int          err_cnt = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        err_due = 1'b0;
  logic        acc_seen = 1'b0;
  logic        pat_en = 1'b0;
  logic [3:0]  pat = 4'b1001;
  int          pat_idx = 0;

  function automatic logic [31:0] word_of(input int fid, input int l, input int k);
    return {8'(fid), 8'(l), 16'(k)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference: a closed frame becomes LANES*len output beats, lane-major.
  task automatic monitor();
    beat_t a;
    beat_t e;
    acc_seen = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      pf_len = 0; closed = 0; done = 0; err_due = 1'b0;
      return;
    end
    a = '{tdata: m_tdata, lane: m_lane, fend: m_frame_end};
    if (m_tvalid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_beat: got %0h required no beat", a);
      end else begin
        e = exp_q[0];
        chk("out_beat", 64'(a), 64'(e));
        if (m_tready) begin
          void'(exp_q.pop_front());
          out_cnt++;
          if (a.tdata[0]) tlast_cnt++;
          if (a.fend) fend_cnt++;
          if (e.fend) done++;
        end
      end
    end
    chk("frame_err", 64'(frame_err), 64'(err_due));
    if (frame_err) err_cnt++;
    err_due = 1'b0;
    if (closed - done < 2) chk("s_tready_free", 64'(s_tready), 64'd1);
    if (s_tvalid && s_tready) begin
      acc_seen = 1'b1;
      for (int l = 0; l < LANES; l++) pf[l][pf_len] = s_tdata[32*l+1 +: 32];
      pf_len++;
      if (s_tdata[0] || pf_len == BINS) begin
        err_due = (s_tdata[0] != (pf_len == BINS));
        for (int l = 0; l < LANES; l++) begin
          for (int k = 0; k < pf_len; k++) begin
            e.tdata = {pf[l][k], 1'(k == pf_len - 1)};
            e.lane  = LANE_W'(l);
            e.fend  = (l == LANES - 1) && (k == pf_len - 1);
            exp_q.push_back(e);
          end
        end
        closed++;
        pf_len = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (pat_en) begin
      m_tready = pat[pat_idx % 4];
      pat_idx++;
    end
  endtask

  task automatic send_frame(input int fid, input int nbins, input int tlast_at);
    int guard;
    for (int k = 0; k < nbins; k++) begin
      for (int l = 0; l < LANES; l++) s_tdata[32*l+1 +: 32] = word_of(fid, l, k);
      s_tdata[0] = (k == tlast_at);
      s_tvalid = 1'b1;
      guard = 0;
      do begin
        tick();
        guard++;
      end while (!acc_seen && guard < 300);
      if (!acc_seen) begin
        n_cmp++; n_fail++;
        $display("FAIL send_timeout: frame %0d bin %0d not accepted after %0d cycles", fid, k, guard);
        break;
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int g = 0;
    while ((exp_q.size() != 0 || m_tvalid) && g < budget) begin
      tick();
      g++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0, t0, f0, e0, lat, g;
    s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0; rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_s_tready", 64'(s_tready), 64'd1);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata", 64'(m_tdata), 64'd0);
    chk("rst_m_lane", 64'(m_lane), 64'd0);
    chk("rst_m_frame_end", 64'(m_frame_end), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    rst_n = 1'b1;

    // Nominal frame
    m_tready = 1'b1;
    o0 = out_cnt; t0 = tlast_cnt; f0 = fend_cnt; e0 = err_cnt;
    send_frame(1, 8, 7);
    lat = 0;
    while (!m_tvalid && lat < 10) begin tick(); lat++; end
    chk("first_valid_latency", 64'(lat), 64'd3);
    chk("first_beat_tdata", 64'(m_tdata), 64'({32'h0100_0000, 1'b0}));
    chk("first_beat_lane", 64'(m_lane), 64'd0);
    wait_drain(200);
    chk("nom_out_count", 64'(out_cnt - o0), 64'd32);
    chk("nom_tlast_count", 64'(tlast_cnt - t0), 64'd4);
    chk("nom_frame_end_count", 64'(fend_cnt - f0), 64'd1);
    chk("nom_err_count", 64'(err_cnt - e0), 64'd0);

    // Early tlast at bin 4
    o0 = out_cnt; t0 = tlast_cnt; f0 = fend_cnt; e0 = err_cnt;
    send_frame(4, 5, 4);
    wait_drain(200);
    chk("early_err_count", 64'(err_cnt - e0), 64'd1);
    chk("early_out_count", 64'(out_cnt - o0), 64'd20);
    chk("early_tlast_count", 64'(tlast_cnt - t0), 64'd4);
    chk("early_frame_end_count", 64'(fend_cnt - f0), 64'd1);

    // Missing tlast
    o0 = out_cnt; t0 = tlast_cnt; e0 = err_cnt;
    send_frame(5, 8, -1);
    wait_drain(200);
    chk("missing_err_count", 64'(err_cnt - e0), 64'd1);
    chk("missing_out_count", 64'(out_cnt - o0), 64'd32);
    chk("missing_tlast_count", 64'(tlast_cnt - t0), 64'd4);

    // Back-to-back frames with m_tready toggling 1-0-0-1
    o0 = out_cnt; f0 = fend_cnt; e0 = err_cnt;
    pat_idx = 0; pat_en = 1'b1;
    send_frame(6, 8, 7);
    send_frame(7, 8, 7);
    send_frame(8, 8, 7);
    wait_drain(800);
    pat_en = 1'b0; m_tready = 1'b1;
    chk("b2b_out_count", 64'(out_cnt - o0), 64'd96);
    chk("b2b_frame_end_count", 64'(fend_cnt - f0), 64'd3);
    chk("b2b_err_count", 64'(err_cnt - e0), 64'd0);

    // Both banks full, output stalled
    o0 = out_cnt; f0 = fend_cnt;
    m_tready = 1'b0;
    send_frame(9, 8, 7);
    send_frame(10, 8, 7);
    for (int l = 0; l < LANES; l++) s_tdata[32*l+1 +: 32] = word_of(11, l, 0);
    s_tdata[0] = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("full_stall_s_tready", 64'(s_tready), 64'd0);
    end
    m_tready = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk("release_s_tready", 64'(s_tready), 64'(k == 31));
    end
    send_frame(11, 8, 7);
    wait_drain(400);
    chk("full_out_count", 64'(out_cnt - o0), 64'd96);
    chk("full_frame_end_count", 64'(fend_cnt - f0), 64'd3);

    // Reset in the middle of lane 2
    m_tready = 1'b1;
    send_frame(12, 8, 7);
    g = 0;
    while (!(m_tvalid && m_lane == 2'd2) && g < 100) begin tick(); g++; end
    chk("reached_lane2", 64'(m_tvalid && m_lane == 2'd2), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_s_tready", 64'(s_tready), 64'd1);
    chk("midrst_m_frame_end", 64'(m_frame_end), 64'd0);
    rst_n = 1'b1;
    o0 = out_cnt;
    repeat (20) tick();
    chk("midrst_residual", 64'(out_cnt - o0), 64'd0);
    o0 = out_cnt;
    send_frame(13, 8, 7);
    wait_drain(200);
    chk("post_rst_out_count", 64'(out_cnt - o0), 64'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
